dffrnq_rn_sequencer: RTL
========================

# dffrnq_rn_sequencer

Reset-release sequencer that generates the active-low RN inputs for banks of dffrnq flops, sitting directly upstream of them. On reset or a software request it drives every RN low for a guaranteed minimum number of clock cycles. It then releases the banks one group at a time, in index order, with a fixed gap between groups, so that release-current steps and recovery/removal checks are spread out. It reports BUSY while sequencing and pulses DONE when the last group is released.

## Interface
Parameters:
- NUM_GROUPS, 4, number of independent RN outputs (>=1)
- HOLD_CYCLES, 4, cycles every RN stays low after the triggering edge (>=1); covers the RN_hl minimum pulse width
- GAP_CYCLES, 1, cycles between successive group releases (>=1)

Ports:
- CLK  input  1  clock; all state changes on posedge CLK
- RST  input  1  reset, synchronous to CLK and active-high
- REQ  input  1  soft reset request; sampled each posedge; same effect as RST
- RN  output  NUM_GROUPS  active-low reset to dffrnq bank k (bit k)
- BUSY  output  1  high while any RN bit is low
- DONE  output  1  one-cycle pulse when the final group releases

## Operation
- States: HOLD, RELEASE, IDLE. One counter of width $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1) and one group index of width $clog2(NUM_GROUPS+1).
- Trigger edge: a posedge with RST=1, or with RST=0 and REQ=1.
  - On a trigger edge: RN <= all 0, BUSY <= 1, DONE <= 0, state <= HOLD, counter <= 0, group index <= 0.
  - RST has priority; REQ is ignored while RST=1.
- Reset values (after any RST edge): RN = all 0, BUSY = 1, DONE = 0, state HOLD. Power-up therefore sequences automatically once RST drops.
- HOLD: counter increments each cycle. At the edge that completes HOLD_CYCLES cycles, RN[0] <= 1 and the block goes to RELEASE, or to IDLE if NUM_GROUPS=1.
- RELEASE: every GAP_CYCLES cycles the next RN bit rises. At the edge that raises RN[NUM_GROUPS-1]:
  - state <= IDLE
  - BUSY <= 0
  - DONE <= 1 for exactly one cycle
- IDLE: RN all 1, BUSY 0, DONE 0. Holds until a trigger edge.
- Invariants:
  - RN[k]=1 implies RN[j]=1 for all j<k; bits rise only in index order, one per release edge.
  - No RN bit ever rises on a trigger edge.
  - BUSY = ~&RN at all times.
  - DONE is never high while BUSY=1.
- A trigger mid-sequence (HOLD or RELEASE) restarts from scratch. Every RN bit returns low on that edge, including bits already released, and a full HOLD_CYCLES is counted again.
- A trigger on the same edge as the final release wins: RN all 0, DONE stays 0.
- Holding REQ high continuously keeps all RN low, with the counter restarting every edge.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Trigger edge at E:
  - RN[k] rises at edge E + HOLD_CYCLES + k*GAP_CYCLES.
  - DONE is high from edge E + HOLD_CYCLES + (NUM_GROUPS-1)*GAP_CYCLES for one cycle.
  - BUSY falls at that same edge.
- Defaults: RN[0..3] rise at E+4, E+5, E+6, E+7. DONE is high in the cycle after E+7. Total latency from trigger to DONE is 7 edges.
- Minimum RN low width is HOLD_CYCLES full CLK periods, for every group, every time.
- RN changes only clk-to-q after posedge CLK. Recovery/removal against downstream dffrnq CLK pins on the same clock is closed in STA; GAP_CYCLES separates group release events.

## Test plan
- Power-up with defaults: RST=1 for 3 edges, then 0 → RN=0000, BUSY=1 through E+3; RN=0001 at E+4, 0011 at E+5, 0111 at E+6, 1111 at E+7; DONE=1 for exactly one cycle after E+7; BUSY=0 from E+7.
- IDLE soft request: single-cycle REQ at edge F → RN=0000 at F, same release schedule as above relative to F, DONE pulses once.
- Mid-release restart: REQ at E+5 (RN=0011) → RN=0000 at E+5; RN[0] rises at E+9; no DONE before E+12.
- Collision: REQ on the final-release edge → RN=0000, DONE stays 0, BUSY stays 1; the sequence restarts.
- RST and REQ together with REQ held high for 10 edges → RN held 0000 throughout; release begins HOLD_CYCLES edges after REQ falls.
- Parameter sweep (NUM_GROUPS=1/HOLD=1/GAP=1, and NUM_GROUPS=3/HOLD=6/GAP=3) → release edges match E+HOLD+k*GAP; monotonic-RN and BUSY=~&RN assertions hold on every cycle.

Source files
------------

// File: rtl/dffrnq_rn_sequencer.sv
// dffrnq_rn_sequencer
//   Generates the active-low RN inputs for NUM_GROUPS banks of dffrnq flops.
//   A trigger (RST, or REQ while RST is low) drives every RN low. RN stays low
//   for HOLD_CYCLES edges. The groups are then released in index order, one
//   every GAP_CYCLES edges. BUSY is high while any RN bit is low. DONE pulses
//   for one cycle on the edge that releases the last group.
//
// Ports
//   CLK   in   clock; all state changes on posedge
//   RST   in   synchronous active-high reset; has the same effect as REQ
//   REQ   in   soft reset request, sampled each posedge
//   RN    out  [NUM_GROUPS-1:0] active-low reset to dffrnq bank k (bit k)
//   BUSY  out  high while any RN bit is low
//   DONE  out  one-cycle pulse when the final group releases
//   All outputs are registered.
module dffrnq_rn_sequencer #(
   parameter int NUM_GROUPS  = 4,
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  REQ,
   output logic [NUM_GROUPS-1:0] RN,
   output logic                  BUSY,
   output logic                  DONE
);

   localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int GW      = $clog2(NUM_GROUPS + 1);

   // The counter starts at 0 on the trigger edge. Its terminal value is
   // therefore one less than the cycle count.
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
   localparam logic [GW-1:0] GRP_LAST  = GW'(NUM_GROUPS - 1);

   typedef enum logic [1:0] {S_HOLD, S_RELEASE, S_IDLE} state_t;

   state_t                  state, state_nxt;
   logic [CW-1:0]           cnt, cnt_nxt;
   logic [GW-1:0]           grp, grp_nxt;
   logic [NUM_GROUPS-1:0]   rn_nxt;
   logic                    busy_nxt, done_nxt;
   logic                    trigger;

   // RST and REQ have identical effects, so RST priority needs no extra gating.
   assign trigger = RST | REQ;

   // State register, including the registered outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= S_HOLD;
         cnt   <= '0;
         grp   <= '0;
         RN    <= '0;
         BUSY  <= 1'b1;
         DONE  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         grp   <= grp_nxt;
         RN    <= rn_nxt;
         BUSY  <= busy_nxt;
         DONE  <= done_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      if (trigger) begin
         state_nxt = S_HOLD;
      end else begin
         case (state)
            S_HOLD:
               if (cnt == HOLD_LAST)
                  state_nxt = (NUM_GROUPS == 1) ? S_IDLE : S_RELEASE;
            S_RELEASE:
               if (cnt == GAP_LAST && grp == GRP_LAST)
                  state_nxt = S_IDLE;
            S_IDLE:
               state_nxt = S_IDLE;
            default:
               state_nxt = S_HOLD;
         endcase
      end
   end

   // Output and datapath next values. A trigger always wins, so a release that
   // coincides with a trigger never happens.
   always_comb begin
      rn_nxt   = RN;
      cnt_nxt  = cnt;
      grp_nxt  = grp;
      done_nxt = 1'b0;
      if (trigger) begin
         rn_nxt  = '0;
         cnt_nxt = '0;
         grp_nxt = '0;
      end else begin
         case (state)
            S_HOLD: begin
               if (cnt == HOLD_LAST) begin
                  rn_nxt[0] = 1'b1;
                  cnt_nxt   = '0;
                  grp_nxt   = GW'(1);
                  done_nxt  = (NUM_GROUPS == 1);
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            S_RELEASE: begin
               if (cnt == GAP_LAST) begin
                  // The loop decode avoids indexing RN with the wider group index.
                  for (int k = 0; k < NUM_GROUPS; k++)
                     if (grp == GW'(k)) rn_nxt[k] = 1'b1;
                  cnt_nxt  = '0;
                  grp_nxt  = grp + GW'(1);
                  done_nxt = (grp == GRP_LAST);
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            S_IDLE:
               rn_nxt = '1;
            default: begin
               rn_nxt  = '0;
               cnt_nxt = '0;
               grp_nxt = '0;
            end
         endcase
      end
      busy_nxt = ~&rn_nxt;
   end

endmodule
